// File: rtl/round_sd_axi.sv
// round_sd_axi: streaming first-order error-feedback requantizer.
// Each accepted WIDTH_IN-bit sample is rounded to WIDTH_OUT bits. The rounding
// residual is carried into the next sample, so quantization noise moves to high
// frequency and the output has no DC bias. AXI-stream handshakes on both sides,
// with a single registered output stage (one cycle of latency, full throughput).
// Optional feature macro: ROUND_SD_CLIP_EN. When it is defined, out_tdata
// saturates to the signed WIDTH_OUT range; otherwise out_tdata wraps.
// The error register is always updated from the unclipped quotient.

module round_sd_axi #(
  parameter int WIDTH_IN          = 25,
  parameter int WIDTH_OUT         = 16,
  parameter int ERR_RESET_ON_LAST = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic [WIDTH_IN-1:0]  in_tdata,
  input  logic                 in_tlast,
  input  logic                 in_tvalid,
  output logic                 in_tready,
  output logic [WIDTH_OUT-1:0] out_tdata,
  output logic                 out_tlast,
  output logic                 out_tvalid,
  input  logic                 out_tready
);

  // Number of bits dropped by the requantizer; also the error register width.
  localparam int D = WIDTH_IN - WIDTH_OUT;

  // The saturating build needs one guard bit above the input width to tell
  // whether the rounded quotient left the output range. The wrapping build
  // only needs the low WIDTH_IN bits, because modular addition produces the
  // same low bits whatever the width.
`ifdef ROUND_SD_CLIP_EN
  localparam int SUM_W = WIDTH_IN + 1;
`else
  localparam int SUM_W = WIDTH_IN;
`endif
  localparam int Q_W = SUM_W - D;

  // Rounding offset of half an output LSB.
  localparam logic [SUM_W-1:0] HALF = {{(SUM_W - D){1'b0}}, 1'b1, {(D - 1){1'b0}}};

  logic                 accept;
  logic signed [SUM_W-1:0] sum;
  logic [SUM_W-1:0]     rounded;
  logic [Q_W-1:0]       q;
  logic [D-1:0]         e_next;
  logic [WIDTH_OUT-1:0] out_data;

  logic [D-1:0]         e_q, e_d;
  logic [WIDTH_OUT-1:0] out_tdata_q, out_tdata_d;
  logic                 out_tlast_q, out_tlast_d;
  logic                 out_tvalid_q, out_tvalid_d;

  // The input side may move whenever the output slot is empty or draining.
  assign in_tready  = out_tready || !out_tvalid_q;
  assign accept     = in_tvalid && in_tready;

  assign out_tdata  = out_tdata_q;
  assign out_tlast  = out_tlast_q;
  assign out_tvalid = out_tvalid_q;

  // Datapath: add the fed-back error, round to nearest, and split the result
  // into the output quotient and the new residual. The residual is the low D
  // bits of the rounded sum minus half an LSB, which is just the low D bits with
  // the top bit inverted, always in [-2^(D-1), 2^(D-1)-1].
  always_comb begin
    sum      = SUM_W'($signed(in_tdata)) + SUM_W'($signed(e_q));
    rounded  = sum + HALF;
    q        = rounded[SUM_W-1:D];
    e_next   = {~rounded[D-1], rounded[D-2:0]};
`ifdef ROUND_SD_CLIP_EN
    if (q[Q_W-1] != q[Q_W-2]) begin
      out_data = q[Q_W-1] ? {1'b1, {(WIDTH_OUT - 1){1'b0}}}
                          : {1'b0, {(WIDTH_OUT - 1){1'b1}}};
    end else begin
      out_data = q[WIDTH_OUT-1:0];
    end
`else
    out_data = q;
`endif
  end

  // Next-state for the output stage and the error register. clear wins over
  // the error update but never blocks or alters the sample being accepted.
  always_comb begin
    e_d          = e_q;
    out_tdata_d  = out_tdata_q;
    out_tlast_d  = out_tlast_q;
    out_tvalid_d = out_tvalid_q;

    if (accept) begin
      out_tdata_d  = out_data;
      out_tlast_d  = in_tlast;
      out_tvalid_d = 1'b1;
      if ((ERR_RESET_ON_LAST != 0) && in_tlast) begin
        e_d = '0;
      end else begin
        e_d = e_next;
      end
    end else if (out_tready) begin
      out_tvalid_d = 1'b0;
    end

    if (clear) begin
      e_d = '0;
    end
  end

  // State registers; reset drops any held sample immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q          <= '0;
      out_tdata_q  <= '0;
      out_tlast_q  <= 1'b0;
      out_tvalid_q <= 1'b0;
    end else begin
      e_q          <= e_d;
      out_tdata_q  <= out_tdata_d;
      out_tlast_q  <= out_tlast_d;
      out_tvalid_q <= out_tvalid_d;
    end
  end

endmodule

// File: tb/tb_round_sd_axi.sv
// tb_round_sd_axi: bench for round_sd_axi at WIDTH_IN=8, WIDTH_OUT=4.
// Two instances share the input stream: one without and one with error reset
// on tlast. An integer-arithmetic model tracks the expected output of each and
// is compared every cycle; directed sequences check literal values on top.
// Honours ROUND_SD_CLIP_EN the same way the design does.

module tb_round_sd_axi;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clear = 1'b0;
  logic [7:0] in_tdata = '0;
  logic       in_tlast = 1'b0;
  logic       in_tvalid = 1'b0;
  logic       out_tready = 1'b1;

  logic       in_tready_w [2];
  logic [3:0] out_tdata_w [2];
  logic       out_tlast_w [2];
  logic       out_tvalid_w [2];

  int tests_run = 0;
  int tests_failed = 0;

  // Output beats actually handed downstream, per instance, as {tlast, data}.
  logic [4:0] cap [2][$];

  round_sd_axi #(.WIDTH_IN(8), .WIDTH_OUT(4), .ERR_RESET_ON_LAST(0)) dut0 (
    .clk(clk), .reset(reset), .clear(clear),
    .in_tdata(in_tdata), .in_tlast(in_tlast), .in_tvalid(in_tvalid),
    .in_tready(in_tready_w[0]),
    .out_tdata(out_tdata_w[0]), .out_tlast(out_tlast_w[0]),
    .out_tvalid(out_tvalid_w[0]), .out_tready(out_tready)
  );

  round_sd_axi #(.WIDTH_IN(8), .WIDTH_OUT(4), .ERR_RESET_ON_LAST(1)) dut1 (
    .clk(clk), .reset(reset), .clear(clear),
    .in_tdata(in_tdata), .in_tlast(in_tlast), .in_tvalid(in_tvalid),
    .in_tready(in_tready_w[1]),
    .out_tdata(out_tdata_w[1]), .out_tlast(out_tlast_w[1]),
    .out_tvalid(out_tvalid_w[1]), .out_tready(out_tready)
  );

  // 100 MHz-style free-running clock.
  always #5 clk = ~clk;

  // Round-to-nearest of s/16 with halves going up: floor((s + 8) / 16).
  function automatic int round_q(input int s);
    int t;
    t = s + 8;
    if (t >= 0) return t / 16;
    return -((-t + 15) / 16);
  endfunction

  // What a quotient looks like on the 4-bit output.
  function automatic logic [3:0] out_val(input int q);
`ifdef ROUND_SD_CLIP_EN
    if (q > 7) return 4'h7;
    if (q < -8) return 4'h8;
`endif
    return q[3:0];
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Expected state per instance: output slot contents and the running error.
  logic       mv [2];
  logic [3:0] md [2];
  logic       ml [2];
  int         me [2];

  // Reference model of the stream behaviour in plain integer arithmetic.
  always @(posedge clk or posedge reset) begin
    int  s, q;
    logic rdy;
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        mv[k] <= 1'b0;
        md[k] <= '0;
        ml[k] <= 1'b0;
        me[k] <= 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        rdy = out_tready || !mv[k];
        if (in_tvalid && rdy) begin
          s = $signed(in_tdata) + me[k];
          q = round_q(s);
          md[k] <= out_val(q);
          ml[k] <= in_tlast;
          mv[k] <= 1'b1;
          if (clear || (k == 1 && in_tlast)) me[k] <= 0;
          else me[k] <= s - 16 * q;
        end else begin
          if (out_tready) mv[k] <= 1'b0;
          if (clear) me[k] <= 0;
        end
      end
    end
  end

  // Record every completed output handshake.
  always @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        if (out_tvalid_w[k] && out_tready) cap[k].push_back({out_tlast_w[k], out_tdata_w[k]});
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        checkOutput($sformatf("model tvalid[%0d]", k), int'(out_tvalid_w[k]), int'(mv[k]));
        checkOutput($sformatf("model tready[%0d]", k), int'(in_tready_w[k]),
                    int'(out_tready || !mv[k]));
        if (mv[k]) begin
          checkOutput($sformatf("model tdata[%0d]", k), int'(out_tdata_w[k]), int'(md[k]));
          checkOutput($sformatf("model tlast[%0d]", k), int'(out_tlast_w[k]), int'(ml[k]));
        end
      end
    end
  end

  // One input cycle, driven on the falling edge.
  task automatic applyStimulus(input logic [7:0] d, input logic l, input logic v, input logic c);
    @(negedge clk);
    in_tdata  = d;
    in_tlast  = l;
    in_tvalid = v;
    clear     = c;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic restart();
    @(negedge clk);
    reset = 1'b1;
    in_tvalid = 1'b0;
    clear = 1'b0;
    out_tready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    cap[0].delete();
    cap[1].delete();
  endtask

  // Pop one captured beat and compare it with a hand-computed value.
  task automatic checkBeat(input int k, input string name, input logic [3:0] d, input logic l);
    logic [4:0] b;
    if (cap[k].size() == 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL %s: got no output beat, expected data %0h last %0b", name, d, l);
    end else begin
      b = cap[k].pop_front();
      checkOutput({name, " data"}, int'(b[3:0]), int'(d));
      checkOutput({name, " last"}, int'(b[4]), int'(l));
    end
  endtask

  initial begin
    int sum;
    real mean;
    logic [3:0] sat_out;
`ifdef ROUND_SD_CLIP_EN
    sat_out = 4'h7;
`else
    sat_out = 4'h8;
`endif

    // Reset values.
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checkOutput("reset tvalid", int'(out_tvalid_w[k]), 0);
      checkOutput("reset tdata", int'(out_tdata_w[k]), 0);
      checkOutput("reset tlast", int'(out_tlast_w[k]), 0);
    end
    @(negedge clk);
    reset = 1'b0;

    // Half-LSB constant dithers 1,0,1,0 at full rate.
    for (int i = 0; i < 6; i++) applyStimulus(8'h08, 1'b0, 1'b1, 1'b0);
    idle(2);
    for (int i = 0; i < 6; i++) checkBeat(0, "const 0x08", (i % 2 == 0) ? 4'h1 : 4'h0, 1'b0);

    // Quarter-LSB constant repeats 0,1,0,0 and averages to exactly 0.25.
    restart();
    for (int i = 0; i < 4096; i++) applyStimulus(8'h04, 1'b0, 1'b1, 1'b0);
    idle(2);
    checkBeat(0, "const 0x04 #0", 4'h0, 1'b0);
    checkBeat(0, "const 0x04 #1", 4'h1, 1'b0);
    checkBeat(0, "const 0x04 #2", 4'h0, 1'b0);
    checkBeat(0, "const 0x04 #3", 4'h0, 1'b0);
    sum = 1;
    while (cap[0].size() > 0) sum += int'(cap[0].pop_front() & 5'h0F);
    mean = real'(sum) / 4096.0;
    tests_run++;
    if (mean < 0.249 || mean > 0.251) begin
      tests_failed++;
      $display("[TB] FAIL mean 0x04: got %f, expected 0.25", mean);
    end

    // Full-scale input overflows the output; residual is -1 then -2.
    restart();
    applyStimulus(8'h7F, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'h09, 1'b0, 1'b1, 1'b0);
    idle(2);
    checkBeat(0, "0x7F first", sat_out, 1'b0);
    checkBeat(0, "0x09 after e=-1", 4'h1, 1'b0);
    restart();
    applyStimulus(8'h7F, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'h7F, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'h09, 1'b0, 1'b1, 1'b0);
    idle(2);
    checkBeat(0, "0x7F again", sat_out, 1'b0);
    checkBeat(0, "0x7F second", sat_out, 1'b0);
    checkBeat(0, "0x09 after e=-2", 4'h0, 1'b0);

    // Backpressure holds the output and freezes the error register.
    restart();
    applyStimulus(8'h08, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      out_tready = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("stall tdata", int'(out_tdata_w[0]), 1);
      checkOutput("stall tready", int'(in_tready_w[0]), 0);
    end
    @(negedge clk);
    out_tready = 1'b1;
    idle(2);
    checkBeat(0, "held sample", 4'h1, 1'b0);
    checkBeat(0, "after release", 4'h0, 1'b0);

    // Error reset on tlast, and clear coinciding with an accept.
    restart();
    applyStimulus(8'h08, 1'b1, 1'b1, 1'b0);
    applyStimulus(8'h08, 1'b0, 1'b1, 1'b0);
    idle(2);
    checkBeat(1, "rol last", 4'h1, 1'b1);
    checkBeat(1, "rol next", 4'h1, 1'b0);
    checkBeat(0, "norst last", 4'h1, 1'b1);
    checkBeat(0, "norst next", 4'h0, 1'b0);
    restart();
    applyStimulus(8'h08, 1'b1, 1'b1, 1'b0);
    applyStimulus(8'h08, 1'b0, 1'b1, 1'b1);
    applyStimulus(8'h08, 1'b0, 1'b1, 1'b0);
    idle(2);
    checkBeat(1, "rol+clr a", 4'h1, 1'b1);
    checkBeat(1, "rol+clr b", 4'h1, 1'b0);
    checkBeat(1, "rol+clr c", 4'h1, 1'b0);
    checkBeat(0, "clr old e a", 4'h1, 1'b1);
    checkBeat(0, "clr old e b", 4'h0, 1'b0);
    checkBeat(0, "clr old e c", 4'h1, 1'b0);

    // clear on its own between samples.
    restart();
    applyStimulus(8'h08, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'h08, 1'b0, 1'b1, 1'b0);
    idle(2);
    checkBeat(0, "clear idle a", 4'h1, 1'b0);
    checkBeat(0, "clear idle b", 4'h1, 1'b0);

    // Asynchronous reset while a sample is held.
    restart();
    applyStimulus(8'h08, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    out_tready = 1'b0;
    in_tvalid = 1'b0;
    @(posedge clk);
    #2;
    checkOutput("held before reset", int'(out_tvalid_w[0]), 1);
    reset = 1'b1;
    #1;
    checkOutput("async reset tvalid0", int'(out_tvalid_w[0]), 0);
    checkOutput("async reset tvalid1", int'(out_tvalid_w[1]), 0);
    @(negedge clk);
    reset = 1'b0;
    out_tready = 1'b1;
    cap[0].delete();
    cap[1].delete();
    applyStimulus(8'h08, 1'b0, 1'b1, 1'b0);
    idle(2);
    checkBeat(0, "after reset", 4'h1, 1'b0);

    idle(1);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
